bcd_seq_converter: RTL and testbench

//  Multi-cycle, parametrised binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bcd_seq_converter.sv | 135 +++++++++++++
 tb/tb_bcd_seq_converter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BCD_SIGNED_EN to treat binary as two's complement and report the sign on neg.
module bcd_seq_converter #(
  parameter int BITWIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BITWIDTH-1:0]   binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BITWIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [BITWIDTH-1:0]     shift_q, shift_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic                    negpend_q, negpend_d;
  logic                    done_q, done_d;
  logic [AW-1:0]           bcd_q, bcd_d;
  logic                    ovf_q, ovf_d;
  logic                    neg_q, neg_d;

  logic                    sign;
  logic [BITWIDTH-1:0]     mag;
  logic [AW-1:0]           acc_adj;
  logic [3:0]              dig;
  logic [AW+BITWIDTH-1:0]  cat;
  logic [AW+BITWIDTH-1:0]  cat_sh;

  // Magnitude uses BITWIDTH-bit wraparound so the most negative value maps to 2^(BITWIDTH-1).
  always_comb begin
`ifdef BCD_SIGNED_EN
    sign = binary[BITWIDTH-1];
    mag  = sign ? (~binary + BITWIDTH'(1)) : binary;
`else
    sign = 1'b0;
    mag  = binary;
`endif
  end

  always_comb begin
    dig     = '0;
    acc_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = acc_q[4*i +: 4];
      acc_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    cat    = {acc_adj, shift_q};
    cat_sh = cat << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    negpend_d = negpend_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = mag;
          acc_d     = '0;
          cnt_d     = CW'(BITWIDTH);
          sticky_d  = 1'b0;
          negpend_d = sign;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d  = cat_sh[BITWIDTH-1:0];
        acc_d    = cat_sh[AW+BITWIDTH-1 -: AW];
        // Bit leaving the top digit means the value needs more than DIGITS digits.
        sticky_d = sticky_q | acc_adj[AW-1];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = cat_sh[AW+BITWIDTH-1 -: AW];
          ovf_d   = sticky_q | acc_adj[AW-1];
          neg_d   = negpend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      negpend_q <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      negpend_q <= negpend_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign neg      = neg_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: a 5-digit default instance and a 4-digit instance.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel_r;
  logic [15:0] binary;

  logic        start_a, start_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic        ovf_a, ovf_b, neg_a, neg_b;
  logic [19:0] bcd_a;
  logic [15:0] bcd_b;

  logic        busy_m, done_m, ovf_m, neg_m;
  logic [19:0] bcd_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel_r;
  assign start_b = start & sel_r;
  assign busy_m  = sel_r ? busy_b : busy_a;
  assign done_m  = sel_r ? done_b : done_a;
  assign ovf_m   = sel_r ? ovf_b  : ovf_a;
  assign neg_m   = sel_r ? neg_b  : neg_a;
  assign bcd_m   = sel_r ? {4'h0, bcd_b} : bcd_a;

  bcd_seq_converter #(.BITWIDTH(16), .DIGITS(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start_a), .binary(binary),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .neg(neg_a)
  );

  bcd_seq_converter #(.BITWIDTH(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_b), .binary(binary),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .neg(neg_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic sel, input logic [15:0] val);
    @(negedge clk);
    sel_r  = sel;
    binary = val;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle c is the one following the c-th edge after acceptance; optionally pulses start mid-run.
  task automatic wait_done(input int inject_at, output int done_cyc, output int busy_n);
    done_cyc = 0;
    busy_n   = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == inject_at) begin
        start  = 1'b1;
        binary = 16'hFFFF;
      end
      if (c == inject_at + 1) start = 1'b0;
      if (busy_m) busy_n++;
      if (done_m) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic sel, input logic [15:0] val,
                     input logic [19:0] exp_bcd, input logic exp_ovf, input logic exp_neg);
    int dc, bn;
    kick(sel, val);
    wait_done(0, dc, bn);
    chk({tag, "_latency"}, dc, 17);
    chk({tag, "_busy"}, bn, 16);
    chk({tag, "_bcd"}, bcd_m, exp_bcd);
    chk({tag, "_ovf"}, ovf_m, exp_ovf);
    chk({tag, "_neg"}, neg_m, exp_neg);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int nd;
    nd = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      binary = 16'(c * 777);
      if (done_m) nd++;
    end
    chk(tag, nd, 0);
  endtask

  initial begin
    int dc, bn;
    rst    = 1'b1;
    start  = 1'b0;
    sel_r  = 1'b0;
    binary = '0;
    #12;
    chk("rst_bcd", bcd_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_neg", neg_a, 0);
    @(negedge clk);
    rst = 1'b0;

    run("t1_65535", 1'b0, 16'd65535, 20'h65535, 1'b0, 1'b0);
    run("t2_zero",  1'b0, 16'd0,     20'h00000, 1'b0, 1'b0);
    run("t2_nine",  1'b0, 16'd9,     20'h00009, 1'b0, 1'b0);
    run("t2_five",  1'b0, 16'd5,     20'h00005, 1'b0, 1'b0);

    run("t3_12345", 1'b1, 16'd12345, 20'h02345, 1'b1, 1'b0);
    run("t3_999",   1'b1, 16'd999,   20'h00999, 1'b0, 1'b0);
    run("t3_65535", 1'b1, 16'd65535, 20'h05535, 1'b1, 1'b0);
    run("t3_9999",  1'b1, 16'd9999,  20'h09999, 1'b0, 1'b0);

    kick(1'b0, 16'd4321);
    wait_done(5, dc, bn);
    chk("t4_latency", dc, 17);
    chk("t4_busy", bn, 16);
    chk("t4_bcd", bcd_m, 20'h04321);
    binary = 16'd7;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, dc, bn);
    chk("t4b_latency", dc, 17);
    chk("t4b_bcd", bcd_m, 20'h00007);
    quiet("t4_no_extra_done", 20);
    chk("t4_hold_bcd", bcd_m, 20'h00007);

    kick(1'b0, 16'd55555);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_bcd", bcd_a, 0);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet("t5_no_done", 20);
    run("t5_100", 1'b0, 16'd100, 20'h00100, 1'b0, 1'b0);

`ifdef BCD_SIGNED_EN
    run("t6_m1234", 1'b0, 16'hFB2E, 20'h01234, 1'b0, 1'b1);
    run("t6_8000",  1'b0, 16'h8000, 20'h32768, 1'b0, 1'b1);
    run("t6_pos",   1'b0, 16'd42,   20'h00042, 1'b0, 1'b0);
`else
    run("t6_fb2e",  1'b0, 16'hFB2E, 20'h64302, 1'b0, 1'b0);
    run("t6_8000",  1'b0, 16'h8000, 20'h32768, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
